// File: rtl/gzip_reg_bank_if.sv
// rtl/gzip_reg_bank_if.sv - byte-wide memory-mapped register port of the gzip register bank
interface gzip_reg_bank_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wren;
  logic [7:0]            mem_wdata;
  logic                  mem_rden;
  logic [7:0]            mem_rdata;
  logic                  mem_rvalid;

  modport master (
    output mem_addr, mem_wren, mem_wdata, mem_rden,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_addr, mem_wren, mem_wdata, mem_rden,
    output mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/gzip_reg_bank.sv
// rtl/gzip_reg_bank.sv - multi-channel Deflate control/status register bank
// Debug snapshot shadow (0x08-0x13) built only with GZIP_REG_DEBUG_SNAPSHOT_EN.
module gzip_reg_bank #(
  parameter int          NUM_CH     = 4,
  parameter int          ADDR_WIDTH = 5,
  parameter logic [7:0]  DEVICE_ID  = 8'hB9,
  parameter int          RST_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  gzip_reg_bank_if.slave        bus,
  input  logic [96*NUM_CH-1:0]  ch_debug,
  input  logic [NUM_CH-1:0]     ch_done,
  output logic [NUM_CH-1:0]     ch_rst_n,
  output logic [2*NUM_CH-1:0]   ch_btype,
  output logic                  irq
);
  logic [31:0]       addr32;
  logic [3:0]        sel;
  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] status;
  logic [NUM_CH-1:0] mask;
  logic [15:0]       status_x;
  logic [15:0]       mask_x;
  logic [7:0]        rst_cnt [NUM_CH];
  logic [7:0]        dcnt    [NUM_CH];
  logic [7:0]        rd_byte;
  logic [7:0]        rdata_q;
  logic              rvalid_q;
  logic [1:0]        sel_btype;
  logic              sel_run;
  logic [7:0]        sel_dcnt;
  logic              wr_sel, wr_ctrl, wr_status, wr_mask, wr_dcnt;

  assign addr32    = 32'(bus.mem_addr[ADDR_WIDTH-1:0]);
  assign wr_sel    = bus.mem_wren && addr32 == 32'h02;
  assign wr_ctrl   = bus.mem_wren && addr32 == 32'h03;
  assign wr_status = bus.mem_wren && addr32 == 32'h04;
  assign wr_mask   = bus.mem_wren && addr32 == 32'h05;
  assign wr_dcnt   = bus.mem_wren && addr32 == 32'h06;
  assign status_x  = 16'(status);
  assign mask_x    = 16'(mask);
  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_rvalid = rvalid_q;

`ifdef GZIP_REG_DEBUG_SNAPSHOT_EN
  logic [95:0] shadow;
  logic [95:0] sel_debug;

  always_comb begin
    sel_debug = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (sel_hit[c]) sel_debug = ch_debug[96*c +: 96];
  end

  // Byte 0 comes from the live word; the same read freezes the rest for 0x09-0x13.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shadow <= '0;
    else if (bus.mem_rden && addr32 == 32'h08)
      shadow <= sel_debug;
  end
`else
  logic unused_debug;
  assign unused_debug = ^ch_debug;
`endif

  always_comb begin
    sel_hit   = '0;
    sel_btype = 2'b00;
    sel_run   = 1'b0;
    sel_dcnt  = 8'h00;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_hit[c]  = (sel == 4'(c));
      ch_rst_n[c] = run[c] && rst_cnt[c] == 8'h00;
      if (sel == 4'(c)) begin
        sel_btype = ch_btype[2*c +: 2];
        sel_run   = run[c];
        sel_dcnt  = dcnt[c];
      end
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (addr32)
      32'h00:  rd_byte = DEVICE_ID;
      32'h01:  rd_byte = 8'(NUM_CH);
      32'h02:  rd_byte = {4'h0, sel};
      32'h03:  rd_byte = {5'b0, sel_run, sel_btype};
      32'h04:  rd_byte = status_x[7:0];
      32'h05:  rd_byte = mask_x[7:0];
      32'h06:  rd_byte = sel_dcnt;
`ifdef GZIP_REG_DEBUG_SNAPSHOT_EN
      32'h08:  rd_byte = sel_debug[7:0];
`endif
      default: begin
`ifdef GZIP_REG_DEBUG_SNAPSHOT_EN
        for (int b = 1; b < 12; b++)
          if (addr32 == 32'(8 + b)) rd_byte = shadow[8*b +: 8];
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= 4'h0;
      run      <= '0;
      ch_btype <= '0;
      status   <= '0;
      mask     <= '0;
      irq      <= 1'b0;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        rst_cnt[c] <= 8'h00;
        dcnt[c]    <= 8'h00;
      end
    end else begin
      rvalid_q <= bus.mem_rden;
      if (bus.mem_rden) rdata_q <= rd_byte;
      irq <= |(status & mask);
      // A done pulse beats a simultaneous write-1-to-clear of the same bit.
      status <= (wr_status ? (status & ~NUM_CH'(bus.mem_wdata)) : status) | ch_done;
      if (wr_mask) mask <= NUM_CH'(bus.mem_wdata);
      if (wr_sel && 32'(bus.mem_wdata) < NUM_CH) sel <= bus.mem_wdata[3:0];
      for (int c = 0; c < NUM_CH; c++) begin
        if (wr_ctrl && sel_hit[c]) begin
          run[c] <= bus.mem_wdata[2];
          if (!bus.mem_wdata[1]) ch_btype[2*c +: 2] <= bus.mem_wdata[1:0];
        end
        if (wr_ctrl && sel_hit[c] && bus.mem_wdata[7])
          rst_cnt[c] <= 8'(RST_CYCLES);
        else if (rst_cnt[c] != 8'h00)
          rst_cnt[c] <= rst_cnt[c] - 8'h01;
        if (wr_dcnt && sel_hit[c])
          dcnt[c] <= {7'b0, ch_done[c]};
        else if (ch_done[c] && dcnt[c] != 8'hFF)
          dcnt[c] <= dcnt[c] + 8'h01;
      end
    end
  end
endmodule

// File: tb/tb_gzip_reg_bank.sv
// tb/tb_gzip_reg_bank.sv - directed table-driven bench for gzip_reg_bank
module tb_gzip_reg_bank;
  localparam int NUM_CH = 4;

  typedef struct {
    bit         is_wr;
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [96*NUM_CH-1:0] ch_debug;
  logic [NUM_CH-1:0]    ch_done;
  logic [NUM_CH-1:0]    ch_rst_n;
  logic [2*NUM_CH-1:0]  ch_btype;
  logic                 irq;
  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [22];

  gzip_reg_bank_if #(.ADDR_WIDTH(5)) bus ();

  gzip_reg_bank #(.NUM_CH(NUM_CH), .ADDR_WIDTH(5), .DEVICE_ID(8'hB9), .RST_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ch_debug(ch_debug), .ch_done(ch_done),
    .ch_rst_n(ch_rst_n), .ch_btype(ch_btype), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wren = 1'b1;
    @(negedge clk);
    bus.mem_wren = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string nm);
    @(negedge clk);
    bus.mem_addr = a; bus.mem_rden = 1'b1;
    @(negedge clk);
    bus.mem_rden = 1'b0;
    chk({nm, "_rvalid"}, 32'(bus.mem_rvalid), 32'd1);
    chk(nm, 32'(bus.mem_rdata), 32'(exp));
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] m);
    @(negedge clk);
    ch_done = m;
    @(negedge clk);
    ch_done = '0;
  endtask

  // Soft-reset CTRL write on channel 1; counts cycles ch_rst_n[1] stays low, optional reload write.
  task automatic measure_low(input int reload_at, output int n);
    @(negedge clk);
    bus.mem_addr = 5'h03; bus.mem_wdata = 8'h84; bus.mem_wren = 1'b1;
    @(negedge clk);
    n = 0;
    while (ch_rst_n[1] == 1'b0 && n < 100) begin
      n++;
      bus.mem_wren = (n == reload_at);
      @(negedge clk);
    end
    bus.mem_wren = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] exp_b;
    bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wren = 1'b0; bus.mem_rden = 1'b0;
    ch_done = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < 12; b++)
        ch_debug[96*c + 8*b +: 8] = 8'(c * 16 + b);

    vecs[0]  = '{0, 5'h00, 8'h00, 8'hB9, "id"};
    vecs[1]  = '{0, 5'h01, 8'h00, 8'h04, "nch"};
    vecs[2]  = '{0, 5'h04, 8'h00, 8'h00, "status_rst"};
    vecs[3]  = '{0, 5'h02, 8'h00, 8'h00, "sel_rst"};
    vecs[4]  = '{0, 5'h05, 8'h00, 8'h00, "mask_rst"};
    vecs[5]  = '{0, 5'h06, 8'h00, 8'h00, "dcnt_rst"};
    vecs[6]  = '{0, 5'h03, 8'h00, 8'h00, "ctrl_rst"};
    vecs[7]  = '{1, 5'h02, 8'h02, 8'h00, ""};
    vecs[8]  = '{0, 5'h02, 8'h00, 8'h02, "sel_wr"};
    vecs[9]  = '{1, 5'h02, 8'h05, 8'h00, ""};
    vecs[10] = '{0, 5'h02, 8'h00, 8'h02, "sel_oob"};
    vecs[11] = '{1, 5'h03, 8'h05, 8'h00, ""};
    vecs[12] = '{0, 5'h03, 8'h00, 8'h05, "ctrl_wr"};
    vecs[13] = '{1, 5'h03, 8'h03, 8'h00, ""};
    vecs[14] = '{0, 5'h03, 8'h00, 8'h01, "ctrl_bad_btype"};
    vecs[15] = '{1, 5'h05, 8'hFF, 8'h00, ""};
    vecs[16] = '{0, 5'h05, 8'h00, 8'h0F, "mask_width"};
    vecs[17] = '{1, 5'h05, 8'h08, 8'h00, ""};
    vecs[18] = '{0, 5'h05, 8'h00, 8'h08, "mask_wr"};
    vecs[19] = '{1, 5'h1F, 8'hAA, 8'h00, ""};
    vecs[20] = '{0, 5'h1F, 8'h00, 8'h00, "unmapped"};
    vecs[21] = '{0, 5'h07, 8'h00, 8'h00, "unmapped7"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", 32'(bus.mem_rdata), 32'h00);
    chk("rst_rvalid", 32'(bus.mem_rvalid), 32'h0);
    chk("rst_ch_rst_n", 32'(ch_rst_n), 32'h0);
    chk("rst_btype", 32'(ch_btype), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    for (int i = 0; i < 22; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
    end
    chk("btype_ch2", 32'(ch_btype), 32'h10);
    wr(5'h03, 8'h05);
    chk("run_ch2", 32'(ch_rst_n), 32'h4);

    wr(5'h02, 8'h01);
    measure_low(0, n);
    chk("softrst_len", 32'(n), 32'd16);
    measure_low(10, n);
    chk("softrst_reload_len", 32'(n), 32'd26);
    chk("run_ch1_ch2", 32'(ch_rst_n), 32'h6);

    pulse(4'b1000);
    chk("irq_lag", 32'(irq), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'h1);
    rd(5'h04, 8'h08, "status_done");
    @(negedge clk);
    bus.mem_addr = 5'h04; bus.mem_wdata = 8'h08; bus.mem_wren = 1'b1; ch_done = 4'b1000;
    @(negedge clk);
    bus.mem_wren = 1'b0; ch_done = '0;
    rd(5'h04, 8'h08, "status_set_wins");
    wr(5'h04, 8'h08);
    rd(5'h04, 8'h00, "status_w1c");
    chk("irq_clear", 32'(irq), 32'h0);

    wr(5'h02, 8'h00);
    repeat (3) pulse(4'b0001);
    rd(5'h06, 8'h03, "dcnt_3");
    repeat (297) pulse(4'b0001);
    rd(5'h06, 8'hFF, "dcnt_sat");
    @(negedge clk);
    bus.mem_addr = 5'h06; bus.mem_wdata = 8'h55; bus.mem_wren = 1'b1; ch_done = 4'b0001;
    @(negedge clk);
    bus.mem_wren = 1'b0; ch_done = '0;
    rd(5'h06, 8'h01, "dcnt_clr_done");
    wr(5'h02, 8'h03);
    rd(5'h06, 8'h02, "dcnt_ch3");

    @(negedge clk);
    bus.mem_addr = 5'h05; bus.mem_wdata = 8'h03; bus.mem_wren = 1'b1; bus.mem_rden = 1'b1;
    @(negedge clk);
    bus.mem_wren = 1'b0; bus.mem_rden = 1'b0;
    chk("rw_same_addr", 32'(bus.mem_rdata), 32'h08);
    rd(5'h05, 8'h03, "mask_after_rw");
    @(negedge clk);
    chk("rvalid_drop", 32'(bus.mem_rvalid), 32'h0);
    chk("rdata_hold", 32'(bus.mem_rdata), 32'h03);

    wr(5'h02, 8'h02);
`ifdef GZIP_REG_DEBUG_SNAPSHOT_EN
    rd(5'h08, 8'h20, "dbg0");
`else
    rd(5'h08, 8'h00, "dbg0");
`endif
    ch_debug = ~ch_debug;
    for (int b = 1; b < 12; b++) begin
`ifdef GZIP_REG_DEBUG_SNAPSHOT_EN
      exp_b = 8'(32 + b);
`else
      exp_b = 8'h00;
`endif
      rd(5'(8 + b), exp_b, $sformatf("dbg%0d", b));
    end

    @(negedge clk);
    bus.mem_addr = 5'h00; bus.mem_rden = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(bus.mem_rvalid), 32'h0);
    chk("midrst_rdata", 32'(bus.mem_rdata), 32'h00);
    chk("midrst_ch_rst_n", 32'(ch_rst_n), 32'h0);
    chk("midrst_btype", 32'(ch_btype), 32'h0);
    @(negedge clk);
    bus.mem_rden = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(5'h02, 8'h00, "post_rst_sel");
    rd(5'h05, 8'h00, "post_rst_mask");
    rd(5'h06, 8'h00, "post_rst_dcnt");
    rd(5'h04, 8'h00, "post_rst_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
